// File: rtl/bus_initiator_pkg.sv
// Shared types and constants for the bus initiator: FSM states, bus widths,
// the default idle address and the timeout counter width helper.
package bus_pkg;

  localparam int BUS_DATA_W = 16;
  localparam int BUS_ADDR_W = 32;

  // Must never decode to a peripheral so an idle bus selects nobody.
  localparam logic [BUS_ADDR_W-1:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One bit wider than needed so the count can reach the limit itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake between the CPU/datapath side and the initiator.
// valid/ready: a transfer happens on a rising edge where both are 1; the
// source holds its payload stable while valid=1 and ready=0.
interface bus_initiator_if
  import bus_pkg::*;
();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [BUS_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [BUS_DATA_W-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/bus_initiator_tristate.sv
// Tri-state driver for a shared bus: drives data_i when en_i, else releases.
module triState #(
  parameter int W = 16
) (
  input  logic [W-1:0] data_i,
  input  logic         en_i,
  inout  wire  [W-1:0] bus_io
);

  assign bus_io = en_i ? data_i : {W{1'bz}};

endmodule

// File: rtl/bus_initiator.sv
// Master end of the shared 16-bit tri-state bus. Optional read timeout is
// enabled by defining BUS_TIMEOUT_EN; without it READ waits indefinitely.
module bus_initiator
  import bus_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] IDLE_ADDR = DEFAULT_IDLE_ADDR
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  bus_initiator_if.slave        req,
  inout  wire  [BUS_DATA_W-1:0] BUS,
  output logic [BUS_ADDR_W-1:0] address,
  output logic                  writeEn,
  output logic                  outputEn,
  input  logic                  readDone,
  output state_e                state_o
);

  state_e                state_q;
  logic [BUS_ADDR_W-1:0] address_q;
  logic [BUS_DATA_W-1:0] wdata_q;
  logic                  writeEn_q;
  logic                  outputEn_q;
  logic                  rsp_valid_q;
  logic [BUS_DATA_W-1:0] rsp_rdata_q;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rsp_error_q;

  assign cnt_d         = cnt_q + 1'b1;
  assign req.rsp_error = rsp_error_q;
`else
  assign req.rsp_error = 1'b0;
`endif

  assign req.req_ready = (state_q == IDLE);
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = rsp_rdata_q;
  assign address       = address_q;
  assign writeEn       = writeEn_q;
  assign outputEn      = outputEn_q;
  assign state_o       = state_q;

  // BUS is driven only while the write strobe is up, never during a read.
  triState #(.W(BUS_DATA_W)) u_bus_drv (
    .data_i (wdata_q),
    .en_i   (state_q == WRITE),
    .bus_io (BUS)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      address_q   <= IDLE_ADDR;
      wdata_q     <= '0;
      writeEn_q   <= 1'b0;
      outputEn_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            address_q <= req.req_addr;
            wdata_q   <= req.req_wdata;
            if (req.req_write) begin
              state_q   <= WRITE;
              writeEn_q <= 1'b1;
            end else begin
              state_q    <= READ;
              outputEn_q <= 1'b1;
`ifdef BUS_TIMEOUT_EN
              cnt_q      <= '0;
`endif
            end
          end
        end
        WRITE: begin
          state_q     <= RESP;
          writeEn_q   <= 1'b0;
          address_q   <= IDLE_ADDR;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
          rsp_error_q <= 1'b0;
`endif
        end
        READ: begin
`ifdef BUS_TIMEOUT_EN
          cnt_q <= cnt_d;
`endif
          // Only a clean 1 completes the read; X/Z falls to the else path.
          if (readDone == 1'b1) begin
            state_q     <= RESP;
            outputEn_q  <= 1'b0;
            address_q   <= IDLE_ADDR;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= BUS;
`ifdef BUS_TIMEOUT_EN
            rsp_error_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            outputEn_q  <= 1'b0;
            address_q   <= IDLE_ADDR;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (req.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a divider peripheral at 0x10..0x13
// (A, B, A/B, A%B) modelled here with a registered readDone.
module tb_bus_initiator;
  import bus_pkg::*;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  wire  [15:0] BUS;
  logic [31:0] address;
  logic        writeEn;
  logic        outputEn;
  logic        readDone;
  state_e      state_o;

  int checks = 0;
  int passes = 0;
  int overlap_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  bus_initiator_if req_if();

  bus_initiator dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req_if),
    .BUS      (BUS),
    .address  (address),
    .writeEn  (writeEn),
    .outputEn (outputEn),
    .readDone (readDone),
    .state_o  (state_o)
  );

  // Divider peripheral: registered select/data, drives BUS the cycle after.
  logic [15:0] reg_a = 16'd0;
  logic [15:0] reg_b = 16'd0;
  logic [15:0] rd_data_q = 16'd0;
  logic        rd_q = 1'b0;
  logic        sel;

  assign sel      = (address >= 32'h10) && (address <= 32'h13);
  assign readDone = rd_q;
  assign BUS      = rd_q ? rd_data_q : 16'hzzzz;

  always @(posedge CLOCK_50) begin
    if (writeEn && sel) begin
      case (address[1:0])
        2'd0:    reg_a <= BUS;
        2'd1:    reg_b <= BUS;
        default: ;
      endcase
    end
    rd_q <= outputEn && sel;
    case (address[1:0])
      2'd0:    rd_data_q <= reg_a;
      2'd1:    rd_data_q <= reg_b;
      2'd2:    rd_data_q <= (reg_b == 16'd0) ? 16'hFFFF : reg_a / reg_b;
      default: rd_data_q <= (reg_b == 16'd0) ? reg_a : reg_a % reg_b;
    endcase
  end

  always @(negedge CLOCK_50) begin
    if (writeEn && outputEn) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One transaction: edges counts the acceptance edge as the first.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [15:0] d,
                        input int exp_edges, input logic [15:0] exp_rdata,
                        input logic exp_err, input string name);
    int edges;
    req_if.req_valid = 1'b1;
    req_if.req_write = wr;
    req_if.req_addr  = a;
    req_if.req_wdata = d;
    tick();
    req_if.req_valid = 1'b0;
    req_if.req_addr  = 32'h0000_0BAD;
    req_if.req_wdata = 16'hDEAD;
    edges = 1;
    while (!req_if.rsp_valid && edges < 200) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== exp_edges)
      $display("FAIL %s_latency: got %0d edges, expected %0d", name, edges, exp_edges);
    else passes++;
    checks++;
    if (req_if.rsp_valid !== 1'b1 || req_if.rsp_rdata !== exp_rdata || req_if.rsp_error !== exp_err)
      $display("FAIL %s_rsp: got valid=%b rdata=%h err=%b, expected valid=1 rdata=%h err=%b",
               name, req_if.rsp_valid, req_if.rsp_rdata, req_if.rsp_error, exp_rdata, exp_err);
    else passes++;
    req_if.rsp_ready = 1'b1;
    tick();
    req_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (state_o !== IDLE || req_if.req_ready !== 1'b1 || req_if.rsp_valid !== 1'b0)
      $display("FAIL reset_hs: got state=%0d ready=%b valid=%b, expected 0 1 0",
               state_o, req_if.req_ready, req_if.rsp_valid);
    else passes++;
    checks++;
    if (req_if.rsp_rdata !== 16'h0 || req_if.rsp_error !== 1'b0)
      $display("FAIL reset_rsp: got rdata=%h err=%b, expected 0000 0",
               req_if.rsp_rdata, req_if.rsp_error);
    else passes++;
    checks++;
    if (address !== IDLE_A || writeEn !== 1'b0 || outputEn !== 1'b0)
      $display("FAIL reset_bus: got addr=%h we=%b oe=%b, expected %h 0 0",
               address, writeEn, outputEn, IDLE_A);
    else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_divider();
    do_txn(1'b1, 32'h10, 16'd100, 2, 16'h0, 1'b0, "wr_a");
    do_txn(1'b1, 32'h11, 16'd7,   2, 16'h0, 1'b0, "wr_b");
    do_txn(1'b0, 32'h12, 16'h0,   3, 16'd14, 1'b0, "rd_quot");
    do_txn(1'b0, 32'h13, 16'h0,   3, 16'd2,  1'b0, "rd_rem");
  endtask

  task automatic test_readback();
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b1;
    req_if.req_addr  = 32'h10;
    req_if.req_wdata = 16'hBEEF;
    tick();
    req_if.req_valid = 1'b0;
    checks++;
    if (writeEn !== 1'b1 || outputEn !== 1'b0 || address !== 32'h10 || BUS !== 16'hBEEF)
      $display("FAIL write_cycle: got we=%b oe=%b addr=%h bus=%h, expected 1 0 00000010 beef",
               writeEn, outputEn, address, BUS);
    else passes++;
    tick();
    checks++;
    if (req_if.rsp_valid !== 1'b1 || writeEn !== 1'b0 || address !== IDLE_A)
      $display("FAIL write_resp: got valid=%b we=%b addr=%h, expected 1 0 %h",
               req_if.rsp_valid, writeEn, address, IDLE_A);
    else passes++;
    req_if.rsp_ready = 1'b1;
    tick();
    req_if.rsp_ready = 1'b0;
    do_txn(1'b0, 32'h10, 16'h0, 3, 16'hBEEF, 1'b0, "rd_beef");
  endtask

  task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
    do_txn(1'b0, 32'h500, 16'h0, 17, 16'h0, 1'b1, "timeout");
`else
    int seen;
    seen = 0;
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b0;
    req_if.req_addr  = 32'h500;
    tick();
    req_if.req_valid = 1'b0;
    repeat (1000) begin
      tick();
      if (req_if.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || outputEn !== 1'b1 || address !== 32'h500)
      $display("FAIL no_timeout: got rsp cycles=%0d oe=%b addr=%h, expected 0 1 00000500",
               seen, outputEn, address);
    else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    int waited;
    do_txn(1'b1, 32'h10, 16'd100, 2, 16'h0, 1'b0, "bp_wr_a");
    do_txn(1'b1, 32'h11, 16'd7,   2, 16'h0, 1'b0, "bp_wr_b");
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b0;
    req_if.req_addr  = 32'h12;
    tick();
    req_if.req_valid = 1'b0;
    waited = 0;
    while (!req_if.rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_if.rsp_valid !== 1'b1 || req_if.rsp_rdata !== 16'd14 || req_if.req_ready !== 1'b0 ||
          address !== IDLE_A || req_if.rsp_error !== 1'b0)
        $display("FAIL hold_%0d: got valid=%b rdata=%h ready=%b addr=%h, expected 1 000e 0 %h",
                 i, req_if.rsp_valid, req_if.rsp_rdata, req_if.req_ready, address, IDLE_A);
      else passes++;
      tick();
    end
    req_if.rsp_ready = 1'b1;
    tick();
    req_if.rsp_ready = 1'b0;
    checks++;
    if (state_o !== IDLE || req_if.rsp_valid !== 1'b0 || req_if.req_ready !== 1'b1)
      $display("FAIL release: got state=%0d valid=%b ready=%b, expected 0 0 1",
               state_o, req_if.rsp_valid, req_if.req_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int got;
    int gap;
    int cyc;
    logic [15:0] exp;
    exp_q.push_back(16'd14);
    exp_q.push_back(16'd14);
    got = 0;
    gap = 0;
    cyc = 0;
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b0;
    req_if.req_addr  = 32'h12;
    req_if.rsp_ready = 1'b1;
    while (got < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (req_if.rsp_valid) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
        checks++;
        if (req_if.rsp_rdata !== exp || req_if.rsp_error !== 1'b0)
          $display("FAIL b2b_rsp%0d: got rdata=%h err=%b, expected %h 0",
                   got, req_if.rsp_rdata, req_if.rsp_error, exp);
        else passes++;
        got++;
        if (got == 2) req_if.req_valid = 1'b0;
      end
      if (got == 1 && address === IDLE_A) gap++;
    end
    tick();
    req_if.rsp_ready = 1'b0;
    checks++;
    if (got !== 2) $display("FAIL b2b_count: got %0d responses, expected 2", got);
    else passes++;
    checks++;
    if (gap < 1) $display("FAIL b2b_gap: got %0d idle-address cycles, expected at least 1", gap);
    else passes++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b0;
    req_if.req_addr  = 32'h12;
    tick();
    req_if.req_valid = 1'b0;
    tick();
    checks++;
    if (outputEn !== 1'b1 || readDone !== 1'b1)
      $display("FAIL mid_read: got oe=%b done=%b, expected 1 1", outputEn, readDone);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (outputEn !== 1'b0 || address !== IDLE_A || req_if.rsp_valid !== 1'b0 ||
        req_if.req_ready !== 1'b1 || writeEn !== 1'b0)
      $display("FAIL abort: got oe=%b addr=%h valid=%b ready=%b we=%b, expected 0 %h 0 1 0",
               outputEn, address, req_if.rsp_valid, req_if.req_ready, writeEn, IDLE_A);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if (req_if.rsp_valid !== 1'b0)
      $display("FAIL abort_rsp: got valid=%b, expected 0", req_if.rsp_valid);
    else passes++;
    do_txn(1'b1, 32'h11, 16'd5, 2, 16'h0,  1'b0, "post_wr");
    do_txn(1'b0, 32'h12, 16'h0, 3, 16'd20, 1'b0, "post_rd");
  endtask

  initial begin
    reset            = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_write = 1'b0;
    req_if.req_addr  = 32'h0;
    req_if.req_wdata = 16'h0;
    req_if.rsp_ready = 1'b0;
    test_reset();
    test_divider();
    test_readback();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (overlap_cnt !== 0)
      $display("FAIL strobe_overlap: got %0d cycles with writeEn and outputEn high, expected 0",
               overlap_cnt);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
